// File: rtl/fp_exp_align_seq.sv
// Multi-cycle exponent aligner for the FP add/sub path: shifts the
// smaller-exponent significand right one bit per cycle until exponents match.
// Ports: clk, rst (async high); in_valid/out_ready operand handshake;
//   in_exp_a/in_sig_a/in_exp_b/in_sig_b operands; out_valid/in_ready result
//   handshake; out_exp, out_sig_a, out_sig_b, out_sticky, out_code,
//   out_shift_cnt aligned result.

module comparator #(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0] i_a,
  input  logic [SIZE-1:0] i_b,
  output logic [1:0]      o_code
);
  // 00 equal, 01 a<b, 10 a>b
  always_comb begin
    o_code = 2'b00;
    if (i_a < i_b)
      o_code = 2'b01;
    else if (i_a > i_b)
      o_code = 2'b10;
  end
endmodule

module fp_exp_align_seq #(
  parameter int EXP_SIZE  = 8,
  parameter int MANT_SIZE = 23
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  out_ready,
  input  logic [EXP_SIZE-1:0]   in_exp_a,
  input  logic [MANT_SIZE:0]    in_sig_a,
  input  logic [EXP_SIZE-1:0]   in_exp_b,
  input  logic [MANT_SIZE:0]    in_sig_b,
  output logic                  out_valid,
  input  logic                  in_ready,
  output logic [EXP_SIZE-1:0]   out_exp,
  output logic [MANT_SIZE:0]    out_sig_a,
  output logic [MANT_SIZE:0]    out_sig_b,
  output logic                  out_sticky,
  output logic [1:0]            out_code,
  output logic [EXP_SIZE-1:0]   out_shift_cnt
);

  localparam int SIG = MANT_SIZE + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ALIGN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [EXP_SIZE-1:0] r_exp_a;
  logic [EXP_SIZE-1:0] r_exp_b;
  logic [SIG-1:0]      r_sig_a;
  logic [SIG-1:0]      r_sig_b;
  logic                r_sticky;
  logic [1:0]          r_code;
  logic [EXP_SIZE-1:0] r_cnt;

  logic [EXP_SIZE-1:0] w_cmp_a;
  logic [EXP_SIZE-1:0] w_cmp_b;
  logic [1:0]          w_code;

  // One comparator serves both acceptance (raw inputs) and the align loop.
  assign w_cmp_a = (r_state == S_IDLE) ? in_exp_a : r_exp_a;
  assign w_cmp_b = (r_state == S_IDLE) ? in_exp_b : r_exp_b;

  comparator #(
    .SIZE (EXP_SIZE)
  ) u_cmp (
    .i_a    (w_cmp_a),
    .i_b    (w_cmp_b),
    .o_code (w_code)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // The early exit only forces the exponents equal; the following cycle
  // sees equality and terminates, so there is a single exit path.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (in_valid) w_next = S_ALIGN;
      S_ALIGN: if (w_code == 2'b00) w_next = S_DONE;
      S_DONE:  if (in_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_exp_a  <= '0;
      r_exp_b  <= '0;
      r_sig_a  <= '0;
      r_sig_b  <= '0;
      r_sticky <= 1'b0;
      r_code   <= 2'b00;
      r_cnt    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_exp_a  <= in_exp_a;
            r_exp_b  <= in_exp_b;
            r_sig_a  <= in_sig_a;
            r_sig_b  <= in_sig_b;
            r_code   <= w_code;
            r_sticky <= 1'b0;
            r_cnt    <= '0;
          end
        end
        S_ALIGN: begin
          unique case (w_code)
            2'b01: begin
              if (r_sig_a == '0) begin
                r_exp_a <= r_exp_b;
              end else begin
                r_sig_a  <= {1'b0, r_sig_a[SIG-1:1]};
                r_sticky <= r_sticky | r_sig_a[0];
                r_exp_a  <= r_exp_a + EXP_SIZE'(1);
                r_cnt    <= r_cnt + EXP_SIZE'(1);
              end
            end
            2'b10: begin
              if (r_sig_b == '0) begin
                r_exp_b <= r_exp_a;
              end else begin
                r_sig_b  <= {1'b0, r_sig_b[SIG-1:1]};
                r_sticky <= r_sticky | r_sig_b[0];
                r_exp_b  <= r_exp_b + EXP_SIZE'(1);
                r_cnt    <= r_cnt + EXP_SIZE'(1);
              end
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign out_ready     = (r_state == S_IDLE);
  assign out_valid     = (r_state == S_DONE);
  assign out_exp       = r_exp_a;
  assign out_sig_a     = r_sig_a;
  assign out_sig_b     = r_sig_b;
  assign out_sticky    = r_sticky;
  assign out_code      = r_code;
  assign out_shift_cnt = r_cnt;

endmodule

// File: tb/tb_fp_exp_align_seq.sv
// Directed bench for fp_exp_align_seq: latency, aligned values,
// backpressure, async reset mid-operation and back-to-back handoff.

module tb_fp_exp_align_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [7:0]  in_exp_a;
  logic [23:0] in_sig_a;
  logic [7:0]  in_exp_b;
  logic [23:0] in_sig_b;
  logic        out_valid;
  logic        in_ready;
  logic [7:0]  out_exp;
  logic [23:0] out_sig_a;
  logic [23:0] out_sig_b;
  logic        out_sticky;
  logic [1:0]  out_code;
  logic [7:0]  out_shift_cnt;

  int checks;
  int errors;

  fp_exp_align_seq #(
    .EXP_SIZE  (8),
    .MANT_SIZE (23)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .out_ready     (out_ready),
    .in_exp_a      (in_exp_a),
    .in_sig_a      (in_sig_a),
    .in_exp_b      (in_exp_b),
    .in_sig_b      (in_sig_b),
    .out_valid     (out_valid),
    .in_ready      (in_ready),
    .out_exp       (out_exp),
    .out_sig_a     (out_sig_a),
    .out_sig_b     (out_sig_b),
    .out_sticky    (out_sticky),
    .out_code      (out_code),
    .out_shift_cnt (out_shift_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns after edge k (the accepting edge).
  task automatic start(input logic [7:0] ea, input logic [23:0] sa,
                       input logic [7:0] eb, input logic [23:0] sb);
    int n;
    n = 0;
    while (!out_ready && n < 100) begin
      step();
      n++;
    end
    in_exp_a = ea;
    in_sig_a = sa;
    in_exp_b = eb;
    in_sig_b = sb;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Number of edges after k until out_valid is seen (bounded).
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic chk_res(input string tag, input logic [7:0] e,
                         input logic [23:0] a, input logic [23:0] b,
                         input logic s, input logic [1:0] c,
                         input logic [7:0] cnt);
    chk({tag, "_exp"}, 32'(out_exp), 32'(e));
    chk({tag, "_siga"}, 32'(out_sig_a), 32'(a));
    chk({tag, "_sigb"}, 32'(out_sig_b), 32'(b));
    chk({tag, "_sticky"}, 32'(out_sticky), 32'(s));
    chk({tag, "_code"}, 32'(out_code), 32'(c));
    chk({tag, "_cnt"}, 32'(out_shift_cnt), 32'(cnt));
  endtask

  int lat;

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_ready = 1'b1;
    in_exp_a = '0;
    in_sig_a = '0;
    in_exp_b = '0;
    in_sig_b = '0;
    step();
    step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(out_ready), 32'd1);
    chk_res("rst", 8'h00, 24'h0, 24'h0, 1'b0, 2'b00, 8'd0);
    rst = 1'b0;
    step();

    // 1: equal exponents
    start(8'h80, 24'hC00000, 8'h80, 24'h800000);
    wait_valid(lat);
    chk("t1_lat", 32'(lat), 32'd1);
    chk_res("t1", 8'h80, 24'hC00000, 24'h800000, 1'b0, 2'b00, 8'd0);
    step();
    chk("t1_idle_valid", 32'(out_valid), 32'd0);
    chk("t1_idle_ready", 32'(out_ready), 32'd1);

    // 2: A smaller by 3
    start(8'h7E, 24'hC00001, 8'h81, 24'h900000);
    wait_valid(lat);
    chk("t2_lat", 32'(lat), 32'd4);
    chk_res("t2", 8'h81, 24'h180000, 24'h900000, 1'b1, 2'b01, 8'd3);
    step();

    // 3: early exit, B fully shifted out
    start(8'h90, 24'hA00000, 8'h10, 24'h800000);
    wait_valid(lat);
    chk("t3_lat", 32'(lat), 32'd26);
    chk_res("t3", 8'h90, 24'hA00000, 24'h000000, 1'b1, 2'b10, 8'd24);
    step();

    // 4: backpressure
    in_ready = 1'b0;
    start(8'h7E, 24'hC00001, 8'h81, 24'h900000);
    wait_valid(lat);
    chk("t4_lat", 32'(lat), 32'd4);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_exp_a = 8'h20 + 8'(i);
      in_sig_a = 24'h123456;
      in_exp_b = 8'h01;
      in_sig_b = 24'hFFFFFF;
      step();
      chk("t4_valid", 32'(out_valid), 32'd1);
      chk("t4_ready", 32'(out_ready), 32'd0);
      chk_res("t4", 8'h81, 24'h180000, 24'h900000, 1'b1, 2'b01, 8'd3);
    end
    in_valid = 1'b0;
    in_ready = 1'b1;
    step();
    chk("t4_rel_valid", 32'(out_valid), 32'd0);
    chk("t4_rel_ready", 32'(out_ready), 32'd1);

    // 5: reset during ALIGN
    start(8'h90, 24'hA00000, 8'h10, 24'h800000);
    for (int i = 0; i < 9; i++) step();
    chk("t5_busy", 32'(out_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_ready", 32'(out_ready), 32'd1);
    chk("t5_rst_cnt", 32'(out_shift_cnt), 32'd0);
    step();
    rst = 1'b0;
    step();
    start(8'h7E, 24'hC00001, 8'h81, 24'h900000);
    wait_valid(lat);
    chk("t5_lat", 32'(lat), 32'd4);
    chk_res("t5", 8'h81, 24'h180000, 24'h900000, 1'b1, 2'b01, 8'd3);
    step();

    // 6: back-to-back, new operand held through the handoff
    start(8'h7E, 24'hC00001, 8'h81, 24'h900000);
    wait_valid(lat);
    in_exp_a = 8'h80;
    in_sig_a = 24'hC00000;
    in_exp_b = 8'h80;
    in_sig_b = 24'h800000;
    in_valid = 1'b1;
    chk_res("t6a", 8'h81, 24'h180000, 24'h900000, 1'b1, 2'b01, 8'd3);
    step();
    chk("t6_idle_ready", 32'(out_ready), 32'd1);
    chk("t6_idle_valid", 32'(out_valid), 32'd0);
    step();
    in_valid = 1'b0;
    chk("t6_acc_ready", 32'(out_ready), 32'd0);
    wait_valid(lat);
    chk("t6_lat", 32'(lat), 32'd1);
    chk_res("t6b", 8'h80, 24'hC00000, 24'h800000, 1'b0, 2'b00, 8'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
